// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data load/store beats fetch, one read outstanding at a time.
// Define MEM_ARB_STARVE_EN to force a fetch grant after STARVE_MAX consecutive lost arbitrations.
module mem_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [AWIDTH-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DWIDTH-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [AWIDTH-1:0]   d_addr_i,
  input  logic [DWIDTH-1:0]   d_wdata_i,
  input  logic [DWIDTH/8-1:0] d_wmask_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DWIDTH-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_wmask_o,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i
);

  typedef enum logic {IDLE, WAIT_RD} state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   force_fetch, d_win, if_win;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range
    $error("mem_arbiter: STARVE_MAX must lie in 1..15");
  end

`ifdef MEM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt, starve_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
`ifdef MEM_ARB_STARVE_EN
      starve_cnt <= starve_nxt;
`endif
    end
  end

  // Outputs are forced to 0 while rst is high so the reset cycle is clean.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    force_fetch = 1'b0;
    d_win       = 1'b0;
    if_win      = 1'b0;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
`ifdef MEM_ARB_STARVE_EN
    starve_nxt  = starve_cnt;
`endif
    if (!rst) begin
      case (state)
        IDLE: begin
`ifdef MEM_ARB_STARVE_EN
          force_fetch = (starve_cnt == STARVE_LIM) && if_req_i && d_req_i;
`endif
          d_win  = d_req_i && !force_fetch;
          if_win = if_req_i && !d_win;
          if (d_win) begin
            d_gnt_o     = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_wmask_o = d_wmask_i;
            if (!d_we_i) begin
              state_nxt = WAIT_RD;
              owner_nxt = 1'b1;
            end
          end else if (if_win) begin
            if_gnt_o   = 1'b1;
            mem_req_o  = 1'b1;
            mem_addr_o = if_addr_i;
            state_nxt  = WAIT_RD;
            owner_nxt  = 1'b0;
          end
`ifdef MEM_ARB_STARVE_EN
          if (if_win)
            starve_nxt = 4'd0;
          else if (if_req_i && d_win && starve_cnt != STARVE_LIM)
            starve_nxt = starve_cnt + 4'd1;
`endif
        end
        WAIT_RD: begin
          if (mem_rvalid_i) begin
            if (owner) begin
              d_rvalid_o = 1'b1;
              d_rdata_o  = mem_rdata_i;
            end else begin
              if_rvalid_o = 1'b1;
              if_rdata_o  = mem_rdata_i;
            end
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [DW/8-1:0] d_wmask;
  logic mem_req, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wmask;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_wmask_i(d_wmask), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: is a read in flight, who owns it, and how many arbitrations fetch has lost in a row.
  bit m_busy = 1'b0;
  bit m_owner_data = 1'b0;
  int m_lost = 0;
  logic e_if_gnt = 1'b0, e_d_gnt = 1'b0;

  always @(negedge clk) begin
    logic e_if_rv, e_d_rv, e_req, e_we;
    logic [DW-1:0] e_if_rd, e_d_rd, e_wd;
    logic [AW-1:0] e_addr;
    logic [DW/8-1:0] e_wm;
    bit fetch_wins, data_wins;
    e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_req = 0; e_we = 0;
    e_if_rd = '0; e_d_rd = '0; e_wd = '0; e_addr = '0; e_wm = '0;
    fetch_wins = 0; data_wins = 0;
    if (!rst) begin
      if (!m_busy) begin
        if (d_req && !(STARVE_ON && m_lost >= SMAX && if_req)) data_wins = 1;
        else if (if_req) fetch_wins = 1;
        if (data_wins) begin
          e_d_gnt = 1; e_req = 1; e_we = d_we; e_addr = d_addr; e_wd = d_wdata; e_wm = d_wmask;
        end else if (fetch_wins) begin
          e_if_gnt = 1; e_req = 1; e_addr = if_addr;
        end
      end else if (mem_rvalid) begin
        if (m_owner_data) begin e_d_rv = 1; e_d_rd = mem_rdata; end
        else begin e_if_rv = 1; e_if_rd = mem_rdata; end
      end
    end
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("mem_req", mem_req, e_req);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("mem_wmask", mem_wmask, e_wm);
    chk("if_rvalid", if_rvalid, e_if_rv);
    chk("if_rdata", if_rdata, e_if_rd);
    chk("d_rvalid", d_rvalid, e_d_rv);
    chk("d_rdata", d_rdata, e_d_rd);
    // Advance the model to the state after the coming clock edge.
    if (rst) begin
      m_busy = 0; m_owner_data = 0; m_lost = 0;
    end else if (m_busy) begin
      if (mem_rvalid) m_busy = 0;
    end else begin
      if (fetch_wins) begin m_busy = 1; m_owner_data = 0; end
      if (data_wins && !d_we) begin m_busy = 1; m_owner_data = 1; end
      if (STARVE_ON) begin
        if (fetch_wins) m_lost = 0;
        else if (if_req && data_wins && m_lost < SMAX) m_lost++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wmask = '0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  initial begin
    rst = 1;
    quiet();
    step(); step();
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);

    // Fetch-only read of 0x100
    step(); rst = 0; quiet();
    step(); if_req = 1; if_addr = 32'h100; #1;
    chk("f_gnt", if_gnt, 1); chk("f_addr", mem_addr, 32'h100); chk("f_we", mem_we, 0);
    step(); quiet(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("f_rvalid", if_rvalid, 1); chk("f_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_d_rvalid", d_rvalid, 0);
    step(); quiet();

    // Simultaneous fetch 0x200 and load 0x300
    step(); if_req = 1; if_addr = 32'h200; d_req = 1; d_addr = 32'h300; #1;
    chk("s_d_gnt", d_gnt, 1); chk("s_if_gnt0", if_gnt, 0); chk("s_addr", mem_addr, 32'h300);
    step(); d_req = 0; d_addr = '0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001; #1;
    chk("s_d_rvalid", d_rvalid, 1); chk("s_d_rdata", d_rdata, 32'hCAFE0001);
    chk("s_if_wait", if_gnt, 0);
    step(); mem_rvalid = 0; #1;
    chk("s_if_gnt", if_gnt, 1); chk("s_if_addr", mem_addr, 32'h200);
    step(); quiet(); mem_rvalid = 1; mem_rdata = 32'h0BADF00D; #1;
    chk("s_if_rdata", if_rdata, 32'h0BADF00D);
    step(); quiet();

    // Back-to-back stores
    step(); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_wmask = 4'hF; #1;
    chk("st_we", mem_we, 1); chk("st_wdata", mem_wdata, 32'h12345678); chk("st_wmask", mem_wmask, 4'hF);
    step(); d_addr = 32'h44; d_wdata = 32'h9ABCDEF0; d_wmask = 4'h3; #1;
    chk("st2_gnt", d_gnt, 1); chk("st2_we", mem_we, 1);
    step(); quiet(); #1;
    chk("st_done_we", mem_we, 0); chk("st_done_req", mem_req, 0);

    // Continuous stores with a held fetch request
    for (int i = 0; i < 6; i++) begin
      step();
      if_req = 1; if_addr = 32'h500;
      d_req = 1; d_we = 1; d_addr = 32'h600 + 32'(i * 4); d_wdata = 32'(i); d_wmask = 4'hF;
      #1;
      if (STARVE_ON) begin
        chk("sv_d_gnt", d_gnt, (i < 4) ? 1'b1 : 1'b0);
        chk("sv_if_gnt", if_gnt, (i == 4) ? 1'b1 : 1'b0);
      end else begin
        chk("sv_d_gnt", d_gnt, 1);
        chk("sv_if_gnt", if_gnt, 0);
      end
    end
    step(); quiet(); mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    step(); quiet();

    // Reset while waiting on a read; late rvalid must be dropped
    step(); if_req = 1; if_addr = 32'h700; #1;
    chk("r_gnt", if_gnt, 1);
    step(); rst = 1; mem_rvalid = 1; mem_rdata = 32'h11112222; d_req = 1; d_addr = 32'h800; #1;
    chk("r_rst_if_rv", if_rvalid, 0); chk("r_rst_d_gnt", d_gnt, 0);
    chk("r_rst_req", mem_req, 0); chk("r_rst_addr", mem_addr, 0);
    step(); rst = 0; quiet(); mem_rvalid = 1; mem_rdata = 32'h33334444; #1;
    chk("r_late_if_rv", if_rvalid, 0); chk("r_late_d_rv", d_rvalid, 0);
    chk("r_late_rdata", if_rdata, 0);
    step(); quiet();

    // Randomized traffic; requests are held until the model says they were granted
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      if (!(if_req && !e_if_gnt) || $urandom_range(0, 19) == 0) begin
        if_req = $urandom_range(0, 1);
        if_addr = $urandom;
      end
      if (!(d_req && !e_d_gnt) || $urandom_range(0, 19) == 0) begin
        d_req = $urandom_range(0, 1);
        d_we = $urandom_range(0, 1);
        d_addr = $urandom;
        d_wdata = $urandom;
        d_wmask = 4'($urandom);
      end
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end
    step(); quiet(); rst = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
